// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point configuration, regression FSM state type and
// saturating arithmetic helpers for the LSM datapath.
package fpga_cfg_pkg;

  localparam int FP_WIDTH = 32;
  localparam int FP_QINT  = 16;
  localparam int FP_QFRAC = 16;

  localparam logic signed [FP_WIDTH-1:0] FP_ONE = FP_WIDTH'(1) << FP_QFRAC;

  typedef enum logic [3:0] {
    IDLE,
    PIVOT,
    SWAP,
    RECIP,
    NORM,
    ELIM,
    BACK,
    FALLBACK,
    DONE
  } regression_state_e;

  // Clamp a wide signed value to the signed w-bit range (w <= 64).
  function automatic logic signed [63:0] fx_sat(input logic signed [127:0] v,
                                                input int w);
    logic signed [127:0] mx;
    logic signed [127:0] mn;
    mx = (128'sd1 <<< (w - 1)) - 128'sd1;
    mn = -mx - 128'sd1;
    if (v > mx)      return mx[63:0];
    else if (v < mn) return mn[63:0];
    else             return v[63:0];
  endfunction

  // Q-format multiply: full product, arithmetic shift (floor), saturate.
  function automatic logic signed [63:0] fx_mul_sat(input logic signed [63:0] a,
                                                    input logic signed [63:0] b,
                                                    input int w,
                                                    input int qf);
    logic signed [127:0] pa;
    logic signed [127:0] pb;
    logic signed [127:0] p;
    pa = a;
    pb = b;
    p  = (pa * pb) >>> qf;
    return fx_sat(p, w);
  endfunction

  // Saturating subtract a - b within the signed w-bit range.
  function automatic logic signed [63:0] fx_sub_sat(input logic signed [63:0] a,
                                                    input logic signed [63:0] b,
                                                    input int w);
    logic signed [127:0] pa;
    logic signed [127:0] pb;
    pa = a;
    pb = b;
    return fx_sat(pa - pb, w);
  endfunction

endpackage

// File: rtl/fx_div_iter.sv
// Sequential restoring signed divider: quo = (num << QFRAC) / den,
// truncated toward zero and saturated. WIDTH+QFRAC cycles from start to done.
module fx_div_iter
  import fpga_cfg_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int QFRAC = FP_QFRAC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] num,
  input  logic signed [WIDTH-1:0] den,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] quo
);

  localparam int N    = WIDTH + QFRAC;
  localparam int CNTW = $clog2(N + 1);

  logic [N-1:0]            dvd;
  logic [N-2:0]            q;
  logic [N-1:0]            q_next;
  logic [WIDTH-1:0]        rem;
  logic [WIDTH:0]          dmag;
  logic [WIDTH:0]          rem_sh;
  logic                    ge;
  logic                    neg;
  logic [CNTW-1:0]         cnt;
  logic signed [WIDTH-1:0] res;

  function automatic logic [WIDTH:0] mag(input logic signed [WIDTH-1:0] x);
    logic [WIDTH:0] e;
    e = {x[WIDTH-1], x};
    return x[WIDTH-1] ? (~e + 1'b1) : e;
  endfunction

  // One restoring step and the signed, saturated form of the final quotient.
  always_comb begin
    rem_sh = {rem, dvd[N-1]};
    ge     = (rem_sh >= dmag);
    q_next = {q, ge};
    if (neg) begin
      if ((|q_next[N-1:WIDTH]) || (q_next[WIDTH-1] && (|q_next[WIDTH-2:0])))
        res = {1'b1, {(WIDTH-1){1'b0}}};
      else
        res = -$signed(q_next[WIDTH-1:0]);
    end else if (|q_next[N-1:WIDTH-1]) begin
      res = {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res = q_next[WIDTH-1:0];
    end
  end

  // Load magnitudes on start, then shift-subtract one quotient bit per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      dvd  <= '0;
      q    <= '0;
      rem  <= '0;
      dmag <= '0;
      neg  <= 1'b0;
      quo  <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy <= 1'b1;
        cnt  <= CNTW'(N);
        dvd  <= {WIDTH'(mag(num)), {QFRAC{1'b0}}};
        q    <= '0;
        rem  <= '0;
        dmag <= mag(den);
        neg  <= num[WIDTH-1] ^ den[WIDTH-1];
      end else if (busy) begin
        dvd <= {dvd[N-2:0], 1'b0};
        q   <= q_next[N-2:0];
        rem <= WIDTH'(ge ? (rem_sh - dmag) : rem_sh);
        cnt <= cnt - 1'b1;
        if (cnt == CNTW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          quo  <= res;
        end
      end
    end
  end

endmodule

// File: rtl/regression_n.sv
// NB x NB least-squares normal-equation solver: Gaussian elimination with
// partial pivoting over one shared divider, mean-payoff fallback when singular.
module regression_n
  import fpga_cfg_pkg::*;
#(
  parameter int NB      = 3,
  parameter int WIDTH   = FP_WIDTH,
  parameter int QINT    = FP_QINT,
  parameter int QFRAC   = FP_QFRAC,
  parameter int PIV_EPS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH*NB*(NB+1)-1:0]   mat_flat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH*NB-1:0]          beta,
  output logic                         singular_err
);

  if (NB < 2 || NB > 6 || QINT + QFRAC != WIDTH) begin : g_bad_cfg
    $error("regression_n: illegal NB/WIDTH/QINT/QFRAC combination");
  end

  localparam int RW = $clog2(NB);
  localparam int CW = $clog2(NB + 1);
  localparam logic [RW-1:0] KLAST = RW'(NB - 1);
  localparam logic [CW-1:0] JLAST = CW'(NB);
  localparam logic [WIDTH-1:0] EPS = WIDTH'(PIV_EPS);
  localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1) << QFRAC;

  regression_state_e state;

  logic signed [WIDTH-1:0] a [NB][NB+1];
  logic signed [WIDTH-1:0] beta_r [NB];
  logic [RW-1:0]           k, r, piv_row, i, nrow;
  logic [CW-1:0]           j;
  logic [WIDTH-1:0]        piv_max, nmax, mag_r;
  logic signed [WIDTH-1:0] recip, acc, sum1, sumy;
  logic signed [WIDTH-1:0] prod_norm, elim_val, back_val;
  logic                    fb_busy;

  logic                    div_start, div_busy, div_done;
  logic signed [WIDTH-1:0] div_num, div_den, div_quo;

  function automatic logic signed [WIDTH-1:0] mul(input logic signed [WIDTH-1:0] x,
                                                  input logic signed [WIDTH-1:0] y);
    return WIDTH'(fx_mul_sat(64'(x), 64'(y), WIDTH, QFRAC));
  endfunction

  function automatic logic signed [WIDTH-1:0] sub(input logic signed [WIDTH-1:0] x,
                                                  input logic signed [WIDTH-1:0] y);
    return WIDTH'(fx_sub_sat(64'(x), 64'(y), WIDTH));
  endfunction

  function automatic logic [WIDTH-1:0] absu(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? WIDTH'(-x) : WIDTH'(x);
  endfunction

  fx_div_iter #(
    .WIDTH(WIDTH),
    .QFRAC(QFRAC)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .start(div_start),
    .num  (div_num),
    .den  (div_den),
    .busy (div_busy),
    .done (div_done),
    .quo  (div_quo)
  );

  // Per-cycle datapath: pivot candidate, normalise product, elimination and back-substitution MAC.
  always_comb begin
    mag_r = absu(a[r][CW'(k)]);
    if (r == k || mag_r > piv_max) begin
      nmax = mag_r;
      nrow = r;
    end else begin
      nmax = piv_max;
      nrow = piv_row;
    end
    prod_norm = mul(a[k][j], recip);
    elim_val  = sub(a[i][j], mul(a[i][CW'(k)], a[k][j]));
    back_val  = acc;
    if (j < JLAST) back_val = sub(acc, mul(a[i][j], beta_r[RW'(j)]));
  end

  // Flatten the coefficient registers onto the output bus.
  always_comb begin
    beta = '0;
    for (int unsigned n = 0; n < NB; n++) beta[n*WIDTH +: WIDTH] = beta_r[n];
  end

  // Solver FSM: all working state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      singular_err <= 1'b0;
      k            <= '0;
      r            <= '0;
      piv_row      <= '0;
      i            <= '0;
      j            <= '0;
      piv_max      <= '0;
      recip        <= '0;
      acc          <= '0;
      sum1         <= '0;
      sumy         <= '0;
      fb_busy      <= 1'b0;
      div_start    <= 1'b0;
      div_num      <= '0;
      div_den      <= '0;
      for (int unsigned ri = 0; ri < NB; ri++) begin
        beta_r[RW'(ri)] <= '0;
        for (int unsigned ci = 0; ci <= NB; ci++) a[RW'(ri)][CW'(ci)] <= '0;
      end
    end else begin
      div_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            for (int unsigned ri = 0; ri < NB; ri++)
              for (int unsigned ci = 0; ci <= NB; ci++)
                a[RW'(ri)][CW'(ci)] <= mat_flat[(ri*(NB+1)+ci)*WIDTH +: WIDTH];
            sum1         <= mat_flat[0 +: WIDTH];
            sumy         <= mat_flat[NB*WIDTH +: WIDTH];
            singular_err <= 1'b0;
            in_ready     <= 1'b0;
            k            <= '0;
            r            <= '0;
            piv_row      <= '0;
            state        <= PIVOT;
          end
        end
        PIVOT: begin
          piv_max <= nmax;
          piv_row <= nrow;
          if (r == KLAST) begin
            if (nmax <= EPS) begin
              singular_err <= 1'b1;
              fb_busy      <= 1'b0;
              for (int unsigned ri = 0; ri < NB; ri++) beta_r[RW'(ri)] <= '0;
              state        <= FALLBACK;
            end else begin
              state <= SWAP;
            end
          end else begin
            r <= r + 1'b1;
          end
        end
        SWAP: begin
          for (int unsigned ci = 0; ci <= NB; ci++) begin
            a[k][CW'(ci)]       <= a[piv_row][CW'(ci)];
            a[piv_row][CW'(ci)] <= a[k][CW'(ci)];
          end
          div_start <= 1'b1;
          div_num   <= ONE;
          div_den   <= a[piv_row][CW'(k)];
          state     <= RECIP;
        end
        RECIP: begin
          if (div_done && !div_busy) begin
            recip <= div_quo;
            j     <= CW'(k) + CW'(1);
            state <= NORM;
          end
        end
        NORM: begin
          a[k][j] <= prod_norm;
          if (j == JLAST) begin
            a[k][CW'(k)] <= ONE;
            // Last pivot row has nothing below it: start back-substitution with the value being written.
            if (k == KLAST) begin
              i     <= KLAST;
              j     <= JLAST;
              acc   <= prod_norm;
              state <= BACK;
            end else begin
              i     <= k + 1'b1;
              j     <= CW'(k) + CW'(1);
              state <= ELIM;
            end
          end else begin
            j <= j + 1'b1;
          end
        end
        ELIM: begin
          a[i][j] <= elim_val;
          if (j == JLAST) begin
            a[i][CW'(k)] <= '0;
            if (i == KLAST) begin
              k     <= k + 1'b1;
              r     <= k + 1'b1;
              state <= PIVOT;
            end else begin
              i <= i + 1'b1;
              j <= CW'(k) + CW'(1);
            end
          end else begin
            j <= j + 1'b1;
          end
        end
        BACK: begin
          if (j == JLAST) begin
            beta_r[i] <= acc;
            if (i == '0) begin
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              i   <= i - 1'b1;
              j   <= CW'(i);
              acc <= a[i - 1'b1][JLAST];
            end
          end else begin
            acc <= back_val;
            j   <= j + 1'b1;
          end
        end
        FALLBACK: begin
          if (!fb_busy) begin
            if (absu(sum1) > EPS) begin
              div_start <= 1'b1;
              div_num   <= sumy;
              div_den   <= sum1;
              fb_busy   <= 1'b1;
            end else begin
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end else if (div_done && !div_busy) begin
            beta_r[0] <= div_quo;
            fb_busy   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
